argmax_scheduler: RTL and testbench

ARGMAX_SCHEDULER -- requirements
Module: argmax_scheduler

---
 rtl/argmax_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_argmax_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_scheduler.sv
// argmax_scheduler: accepts one frame of CO signed scores and scans it one
// score per cycle. It returns the index of the largest score (the lowest
// index wins a tie), the score itself, and a reject flag. The reject flag is
// set when that score is below the threshold captured with the frame.
// Results are held under a valid/ready handshake. i_flush aborts any frame
// in progress and discards it.
module argmax_scheduler #(
  parameter int CO = 26,
  parameter int BW = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CO*BW-1:0]      i_frame,
  input  logic                  i_frame_valid,
  output logic                  o_frame_ready,
  input  logic [BW-1:0]         i_threshold,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [$clog2(CO)-1:0] o_index,
  output logic [BW-1:0]         o_max,
  output logic                  o_reject,
  output logic                  o_busy
);

  localparam int IW = $clog2(CO);
  localparam logic [IW-1:0] LAST_IDX = IW'(CO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CO*BW-1:0]      frame_q, frame_d;
  logic signed [BW-1:0]  thr_q, thr_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         run_idx_q, run_idx_d;
  logic signed [BW-1:0]  run_max_q, run_max_d;
  logic                  valid_q, valid_d;
  logic [IW-1:0]         index_q, index_d;
  logic signed [BW-1:0]  max_q, max_d;
  logic                  reject_q, reject_d;
  logic                  busy_q, busy_d;
  // Low while reset_n is asserted and for the cycle that ends on the first
  // edge after release. o_frame_ready therefore rises only after that edge.
  logic                  armed_q, armed_d;

  logic signed [BW-1:0]  cur_s;
  logic                  gt_s;
  logic signed [BW-1:0]  new_max_s;
  logic [IW-1:0]         new_idx_s;
  logic                  accept_s;

  // Select the stored score at the scan counter. Indices past CO-1 yield 0.
  always_comb begin
    cur_s = '0;
    for (int k = 0; k < CO; k++) begin
      if (cnt_q == IW'(k)) begin
        cur_s = frame_q[k*BW +: BW];
      end else begin
        cur_s = cur_s;
      end
    end
  end

  // Strictly-greater signed compare, so the earlier index keeps a tie.
  always_comb begin
    gt_s      = (cur_s > run_max_q);
    new_max_s = gt_s ? cur_s : run_max_q;
    new_idx_s = gt_s ? cnt_q : run_idx_q;
  end

  // A flush blocks acceptance in the same cycle.
  always_comb begin
    o_frame_ready = armed_q && (state_q == IDLE) && !i_flush;
    accept_s      = i_frame_valid && o_frame_ready;
  end

  // Next-state and datapath: hold everything by default, then apply flush or the state action.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    thr_d     = thr_q;
    cnt_d     = cnt_q;
    run_idx_d = run_idx_q;
    run_max_d = run_max_q;
    valid_d   = valid_q;
    index_d   = index_q;
    max_d     = max_q;
    reject_d  = reject_q;
    armed_d   = 1'b1;
    if (i_flush) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      cnt_d     = '0;
      run_idx_d = '0;
      run_max_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            frame_d   = i_frame;
            thr_d     = i_threshold;
            run_max_d = i_frame[BW-1:0];
            run_idx_d = '0;
            cnt_d     = IW'(1);
            state_d   = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          run_max_d = new_max_s;
          run_idx_d = new_idx_s;
          if (cnt_q == LAST_IDX) begin
            // Last comparison. Publish the result as DONE is entered.
            state_d  = DONE;
            cnt_d    = '0;
            valid_d  = 1'b1;
            index_d  = new_idx_s;
            max_d    = new_max_s;
            reject_d = (new_max_s < thr_q);
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      thr_q     <= '0;
      cnt_q     <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      max_q     <= '0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      thr_q     <= thr_d;
      cnt_q     <= cnt_d;
      run_idx_q <= run_idx_d;
      run_max_q <= run_max_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      max_q     <= max_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
    end
  end

  // Output ports come straight from registers.
  always_comb begin
    o_valid  = valid_q;
    o_index  = index_q;
    o_max    = max_q;
    o_reject = reject_q;
    o_busy   = busy_q;
  end

endmodule

// File: tb/tb_argmax_scheduler.sv
// Self-checking bench for argmax_scheduler (CO=26, BW=20): table-driven
// frames, hand-written corner sequences and random back-to-back frames
// scored against a plain argmax reference model.
module tb_argmax_scheduler;

  localparam int CO = 26;
  localparam int BW = 20;
  localparam int IW = $clog2(CO);
  localparam int SMIN = -(1 << (BW - 1));
  localparam int SMAX = (1 << (BW - 1)) - 1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [CO*BW-1:0]    i_frame;
  logic                i_frame_valid;
  logic                o_frame_ready;
  logic [BW-1:0]       i_threshold;
  logic                i_flush;
  logic                o_valid;
  logic                i_ready;
  logic [IW-1:0]       o_index;
  logic [BW-1:0]       o_max;
  logic                o_reject;
  logic                o_busy;

  argmax_scheduler #(.CO(CO), .BW(BW)) dut (
    .clk(clk), .reset_n(reset_n), .i_frame(i_frame), .i_frame_valid(i_frame_valid),
    .o_frame_ready(o_frame_ready), .i_threshold(i_threshold), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_index(o_index), .o_max(o_max),
    .o_reject(o_reject), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sc [CO];   // scores of the frame currently being built

  typedef struct {
    int kind;     // 0: score[k]=k-13 with one override; 1: all scores equal to val
    int sidx;
    int val;
    int thr;
    int e_idx;
    int e_max;
    int e_rej;
  } vec_t;

  typedef struct {
    int idx;
    int mx;
    int rej;
  } res_t;

  vec_t tbl [8];
  res_t expq [$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Advance one clock. Sampling and driving both happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [CO*BW-1:0] pack();
    logic [CO*BW-1:0] p;
    int v;
    p = '0;
    for (int k = 0; k < CO; k++) begin
      v = sc[k];
      p[k*BW +: BW] = v[BW-1:0];
    end
    return p;
  endfunction

  // Reference: the first index holding the largest value, and whether that value is below thr.
  task automatic ref_model(input int thr, output res_t r);
    r.idx = 0;
    r.mx  = sc[0];
    for (int k = 1; k < CO; k++) begin
      if (sc[k] > r.mx) begin
        r.idx = k;
        r.mx  = sc[k];
      end
    end
    r.rej = (r.mx < thr) ? 1 : 0;
  endtask

  task automatic build(input int kind, input int sidx, input int val);
    for (int k = 0; k < CO; k++) begin
      sc[k] = (kind == 0) ? (k - 13) : val;
    end
    if (kind == 0) sc[sidx] = val;
  endtask

  // Offer the frame in sc and return once it has been accepted (bounded wait).
  task automatic send(input int thr);
    int n;
    int t;
    t = thr;
    i_frame       = pack();
    i_threshold   = t[BW-1:0];
    i_frame_valid = 1'b1;
    n = 0;
    while (!o_frame_ready && n < 60) begin
      step();
      n++;
    end
    if (!o_frame_ready) chk("accept_timeout", 0, 1);
    step();
    i_frame_valid = 1'b0;
  endtask

  // Count the edges from acceptance until o_valid rises.
  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic gen_random();
    int mode;
    int t;
    mode = int'($urandom_range(0, 2));
    t    = int'($urandom_range(0, 6)) - 3;
    for (int k = 0; k < CO; k++) begin
      if (mode == 0) sc[k] = int'($urandom_range(0, (1 << BW) - 1)) + SMIN;
      else if (mode == 1) sc[k] = int'($urandom_range(0, 6)) - 3;
      else sc[k] = t;
    end
    t = (mode == 0) ? int'($urandom_range(0, (1 << BW) - 1)) + SMIN
                    : int'($urandom_range(0, 6)) - 3;
    i_frame     = pack();
    i_threshold = t[BW-1:0];
    i_frame_valid = 1'b1;
  endtask

  int   lat;
  int   nres;
  int   nacc;
  int   last;
  int   cnt;
  int   hold_idx;
  int   hold_max;
  int   cur_thr [$];
  res_t r;
  bit   acc;

  initial begin
    reset_n = 1'b0; i_frame = '0; i_frame_valid = 1'b0; i_threshold = '0;
    i_flush = 1'b0; i_ready = 1'b0;

    // Expected outputs below are worked out by hand from the frame definitions.
    tbl[0] = '{0,  7,  500,    0,  7, 500,  0};
    tbl[1] = '{1,  0,   -5,  -10,  0,  -5,  0};
    tbl[2] = '{1,  0,   -5,   -4,  0,  -5,  1};
    tbl[3] = '{1,  0,   -5,   -5,  0,  -5,  0};
    tbl[4] = '{0, 25,  100,  200, 25, 100,  1};
    tbl[5] = '{0,  0,   12,   12,  0,  12,  0};
    tbl[6] = '{0,  3, SMIN, SMIN, 25,  12,  0};
    tbl[7] = '{1,  0, SMIN, SMAX,  0, SMIN,  1};

    // Reset state
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_index", o_index, 0);
    chk("rst_max", o_max, 0);
    chk("rst_ready", o_frame_ready, 0);
    step(); step();
    reset_n = 1'b1;
    step();
    chk("ready_after_rst", o_frame_ready, 1);
    chk("busy_after_rst", o_busy, 0);

    // Table-driven frames. The acceptance cycle is cycle 1 and o_valid is high in cycle CO, so it rises CO-1 edges after acceptance.
    for (int i = 0; i < 8; i++) begin
      build(tbl[i].kind, tbl[i].sidx, tbl[i].val);
      send(tbl[i].thr);
      chk($sformatf("v%0d_busy", i), o_busy, 1);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), lat, CO - 1);
      chk($sformatf("v%0d_index", i), o_index, tbl[i].e_idx);
      chk($sformatf("v%0d_max", i), $signed(o_max), tbl[i].e_max);
      chk($sformatf("v%0d_reject", i), o_reject, tbl[i].e_rej);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", i), o_valid, 0);
      chk($sformatf("v%0d_ready_idle", i), o_frame_ready, 1);
    end

    // Back-pressure: hold i_ready low for 10 cycles while offering another frame.
    build(0, 9, 777);
    send(0);
    wait_valid(lat);
    chk("bp_latency", lat, CO - 1);
    build(0, 2, 4000);
    i_frame = pack();
    i_frame_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid_hold", o_valid, 1);
      chk("bp_index_hold", o_index, 9);
      chk("bp_max_hold", $signed(o_max), 777);
      chk("bp_ready_low", o_frame_ready, 0);
      step();
    end
    i_frame_valid = 1'b0;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("bp_valid_drop", o_valid, 0);
    chk("bp_idle_busy", o_busy, 0);
    chk("bp_idle_ready", o_frame_ready, 1);

    // Flush while the scan counter is at 12, then check flush priority in IDLE.
    build(0, 5, 300);
    send(0);
    for (int c = 0; c < 11; c++) step();
    i_flush = 1'b1;
    step();
    chk("flush_busy", o_busy, 0);
    chk("flush_valid", o_valid, 0);
    i_frame_valid = 1'b1;
    #1;
    chk("flush_blocks_ready", o_frame_ready, 0);
    step();
    chk("flush_no_accept", o_busy, 0);
    i_flush = 1'b0;
    i_frame_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) cnt++;
      step();
    end
    chk("flush_no_result", cnt, 0);
    build(0, 25, 999);
    send(0);
    wait_valid(lat);
    chk("post_flush_latency", lat, CO - 1);
    chk("post_flush_index", o_index, 25);
    chk("post_flush_max", $signed(o_max), 999);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;

    // Asynchronous reset asserted between edges in the middle of a scan
    build(0, 20, 50);
    send(0);
    for (int c = 0; c < 5; c++) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_index", o_index, 0);
    chk("arst_max", o_max, 0);
    chk("arst_reject", o_reject, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_ready", o_frame_ready, 0);
    #2;
    reset_n = 1'b1;
    step();
    chk("arst_ready_after", o_frame_ready, 1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) cnt++;
      step();
    end
    chk("arst_no_stale", cnt, 0);

    // Random frames offered back to back with i_ready tied high, checked against the reference model
    i_ready = 1'b1;
    nres = 0;
    nacc = 0;
    last = -1;
    gen_random();
    for (int c = 0; c < 8 * (CO + 1) + 60 && nres < 8; c++) begin
      if (o_valid) begin
        if (expq.size() == 0) begin
          chk("b2b_unexpected", 1, 0);
        end else begin
          r = expq.pop_front();
          chk("b2b_index", o_index, r.idx);
          chk("b2b_max", $signed(o_max), r.mx);
          chk("b2b_reject", o_reject, r.rej);
        end
        if (last >= 0) chk("b2b_period", cyc - last, CO + 1);
        last = cyc;
        nres++;
      end
      acc = o_frame_ready && i_frame_valid;
      if (acc) begin
        ref_model($signed(i_threshold), r);
        expq.push_back(r);
        nacc++;
      end
      step();
      if (acc) begin
        if (nacc < 8) gen_random();
        else i_frame_valid = 1'b0;
      end
    end
    chk("b2b_count", nres, 8);
    i_ready = 1'b0;
    i_frame_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
